// File: rtl/softmax_recip_normalizer_pkg.sv
// Shared widths, constants and output beat type for the softmax reciprocal normaliser.
// Latency: none (declarations only).
// Backpressure: not applicable.
package softmax_recip_normalizer_pkg;

  // Q0.7 mantissa sent to the LUT and Q1.8 reciprocal returned from it
  localparam int MANT_W  = 7;
  localparam int RECIP_W = 9;

  // Smallest normalised mantissa (0.5); also the idle/zero-sum LUT address
  localparam logic [MANT_W-1:0] LUT_FLOOR = 7'h40;

  // Reciprocal reported for a zero sum
  localparam logic [RECIP_W-1:0] RECIP_SAT = 9'h1FF;

  // Field widths of the output beat
  localparam int BEAT_EXP_W = 6;
  localparam int BEAT_TAG_W = 4;

  // Largest positive value of an exp_w-bit two's complement exponent
  function automatic int exp_max(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Exponent reported for a zero sum
  localparam logic [BEAT_EXP_W-1:0] EXP_SAT = BEAT_EXP_W'(exp_max(BEAT_EXP_W));

  typedef struct packed {
    logic [RECIP_W-1:0]           mant;
    logic signed [BEAT_EXP_W-1:0] exp;
    logic [BEAT_TAG_W-1:0]        tag;
    logic                         dz;
  } out_beat_t;

endpackage

// File: rtl/softmax_recip_normalizer_if.sv
// Bundles the input stream, reciprocal-LUT port and output stream of the normaliser.
// Latency: none (wiring only).
// Backpressure: valid/ready on input and output streams; the LUT path is combinational.
interface softmax_recip_normalizer_if #(
  parameter int SUM_W = 16,
  parameter int EXP_W = 6,
  parameter int TAG_W = 4
);
  import softmax_recip_normalizer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   in_sum;
  logic [TAG_W-1:0]   in_tag;

  logic [MANT_W-1:0]  lut_m_value;
  logic [RECIP_W-1:0] lut_recip;

  logic               out_valid;
  logic               out_ready;
  logic [RECIP_W-1:0] out_mant;
  logic [EXP_W-1:0]   out_exp;
  logic [TAG_W-1:0]   out_tag;
  logic               out_dz;

  // Normaliser side
  modport slave (
    input  in_valid, in_sum, in_tag, lut_recip, out_ready,
    output in_ready, lut_m_value, out_valid, out_mant, out_exp, out_tag, out_dz
  );

  // Producer / LUT / consumer side
  modport master (
    output in_valid, in_sum, in_tag, lut_recip, out_ready,
    input  in_ready, lut_m_value, out_valid, out_mant, out_exp, out_tag, out_dz
  );

endinterface

// File: rtl/softmax_recip_normalizer_lead_one_det.sv
// Priority encoder: position of the most significant set bit of the sum, plus a zero flag.
// Latency: combinational.
// Backpressure: none.
module softmax_recip_normalizer_lead_one_det #(
  parameter int SUM_W = 16,
  parameter int P_W   = $clog2(SUM_W)
) (
  input  logic [SUM_W-1:0] sum_i,
  output logic [P_W-1:0]   pos_o,
  output logic             zero_o
);

  // Highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum_i[i]) pos_o = P_W'(i);
    end
  end

  assign zero_o = ~|sum_i;

endmodule

// File: rtl/softmax_recip_normalizer.sv
// Normalises the softmax exponent sum to m in [0.5,1), looks up 1/m and emits mant*2^exp.
// Latency: 3 cycles accept-to-out_valid, 1 token per cycle.
// Backpressure: each stage loads when empty or when the next stage loads; bubbles collapse.
module softmax_recip_normalizer
  import softmax_recip_normalizer_pkg::*;
#(
  parameter int SUM_W    = 16,
  parameter int SUM_FRAC = 8,
  parameter int EXP_W    = 6,
  parameter int TAG_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  softmax_recip_normalizer_if.slave  bus
);

  localparam int P_W = $clog2(SUM_W);
  localparam logic [EXP_W-1:0] EXP_SAT_L = EXP_W'(exp_max(EXP_W));

  // The full exponent range must be representable, and the beat type must match
  if ((SUM_FRAC - SUM_W) < -(1 << (EXP_W - 1)) || (SUM_FRAC - 1) > exp_max(EXP_W)) begin : g_exp_range_chk
    $error("softmax_recip_normalizer: exponent range does not fit in EXP_W bits");
  end
  if (EXP_W != BEAT_EXP_W || TAG_W != BEAT_TAG_W) begin : g_beat_chk
    $error("softmax_recip_normalizer: EXP_W/TAG_W must match the output beat fields");
  end

  logic               rdy_en_q;

  logic               s1_vld_q;
  logic [SUM_W-1:0]   s1_sum_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic [P_W-1:0]     s1_p_q;
  logic               s1_dz_q;

  logic               s2_vld_q;
  logic [MANT_W-1:0]  s2_m7_q;
  logic [EXP_W-1:0]   s2_exp_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic               s2_dz_q;

  logic               out_vld_q;
  out_beat_t          out_q;

  logic               s1_ld, s2_ld, s3_ld, in_acc;
  logic [P_W-1:0]     s1_p_d;
  logic               s1_dz_d;
  logic [MANT_W-1:0]  s2_m7_d;
  logic [EXP_W-1:0]   s2_exp_d;

  softmax_recip_normalizer_lead_one_det #(
    .SUM_W (SUM_W),
    .P_W   (P_W)
  ) u_lead_one_det (
    .sum_i  (bus.in_sum),
    .pos_o  (s1_p_d),
    .zero_o (s1_dz_d)
  );

  // Load chain runs backwards from the output register
  assign s3_ld        = bus.out_ready || !out_vld_q;
  assign s2_ld        = !s2_vld_q || s3_ld;
  assign s1_ld        = !s1_vld_q || s2_ld;
  assign bus.in_ready = rdy_en_q && s1_ld;
  assign in_acc       = bus.in_valid && bus.in_ready;

  // Mantissa is the 7 bits from the leading one down, zero-filled below bit 0;
  // the exponent undoes that shift relative to the input's binary point
  always_comb begin
    s2_m7_d  = MANT_W'({s1_sum_q, {(MANT_W-1){1'b0}}} >> s1_p_q);
    s2_exp_d = EXP_W'(SUM_FRAC - 1 - int'(s1_p_q));
    if (s1_dz_q) begin
      s2_m7_d  = LUT_FLOOR;
      s2_exp_d = EXP_SAT_L;
    end
  end

  // Hold in_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // S1: capture the sum and tag with their leading-one position and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sum_q <= '0;
      s1_tag_q <= '0;
      s1_p_q   <= '0;
      s1_dz_q  <= 1'b0;
    end else if (s1_ld) begin
      s1_vld_q <= in_acc;
      if (in_acc) begin
        s1_sum_q <= bus.in_sum;
        s1_tag_q <= bus.in_tag;
        s1_p_q   <= s1_p_d;
        s1_dz_q  <= s1_dz_d;
      end
    end
  end

  // S2: register the normalised mantissa (it addresses the LUT directly) and exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_m7_q  <= LUT_FLOOR;
      s2_exp_q <= '0;
      s2_tag_q <= '0;
      s2_dz_q  <= 1'b0;
    end else if (s2_ld) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_m7_q  <= s2_m7_d;
        s2_exp_q <= s2_exp_d;
        s2_tag_q <= s1_tag_q;
        s2_dz_q  <= s1_dz_q;
      end
    end
  end

  // S3: capture the LUT reciprocal into the output beat; held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (s3_ld) begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_q.mant <= s2_dz_q ? RECIP_SAT : bus.lut_recip;
        out_q.exp  <= s2_exp_q;
        out_q.tag  <= s2_tag_q;
        out_q.dz   <= s2_dz_q;
      end
    end
  end

  assign bus.lut_m_value = s2_m7_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_mant    = out_q.mant;
  assign bus.out_exp     = out_q.exp;
  assign bus.out_tag     = out_q.tag;
  assign bus.out_dz      = out_q.dz;

endmodule

// File: tb/tb_softmax_recip_normalizer.sv
// Self-checking bench for softmax_recip_normalizer: directed vectors, streams, reset.
// Latency: expects 3 cycles accept-to-output.
// Backpressure: drives out_ready in fixed and random patterns.
module tb_softmax_recip_normalizer;

  localparam int SUM_W    = 16;
  localparam int SUM_FRAC = 8;
  localparam int EXP_W    = 6;
  localparam int TAG_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  softmax_recip_normalizer_if #(.SUM_W(SUM_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) bus();

  softmax_recip_normalizer #(
    .SUM_W(SUM_W), .SUM_FRAC(SUM_FRAC), .EXP_W(EXP_W), .TAG_W(TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reciprocal LUT: floor(256 / (m/128)) saturated to 9 bits
  function automatic logic [8:0] lut_model(input logic [6:0] m);
    int v;
    if (m == 7'd0) return 9'h1FF;
    v = 32768 / int'(m);
    if (v > 511) v = 511;
    return 9'(v);
  endfunction

  assign bus.lut_recip = lut_model(bus.lut_m_value);

  typedef struct packed {
    logic [6:0] m7;
    logic [8:0] mant;
    logic [5:0] exp;
    logic [3:0] tag;
    logic       dz;
  } exp_t;

  // Reference: value = sum/256 = m * 2^k with m in [0.5,1); reciprocal = (1/m) * 2^-k
  function automatic exp_t model(input int sum, input logic [3:0] tag);
    exp_t r;
    int   p;
    r.tag = tag;
    if (sum == 0) begin
      r.dz = 1'b1; r.m7 = 7'd64; r.mant = 9'h1FF; r.exp = 6'd31;
      return r;
    end
    p = 0;
    while ((sum >> (p + 1)) != 0) p++;
    r.dz   = 1'b0;
    r.m7   = 7'((sum * 64) >> p);
    r.mant = lut_model(r.m7);
    r.exp  = 6'(SUM_FRAC - 1 - p);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_mant !== 9'h0) begin n_errors++; $display("FAIL reset out_mant: got %0h want 0", bus.out_mant); end
    n_checks++; if (bus.out_exp !== 6'h0) begin n_errors++; $display("FAIL reset out_exp: got %0h want 0", bus.out_exp); end
    n_checks++; if (bus.out_tag !== 4'h0) begin n_errors++; $display("FAIL reset out_tag: got %0h want 0", bus.out_tag); end
    n_checks++; if (bus.out_dz !== 1'b0) begin n_errors++; $display("FAIL reset out_dz: got %0b want 0", bus.out_dz); end
    n_checks++; if (bus.lut_m_value !== 7'h40) begin n_errors++; $display("FAIL reset lut_m_value: got %0h want 40", bus.lut_m_value); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %0b want 1", bus.in_ready); end
  endtask

  // Single token through an idle pipeline, out_ready held high
  task automatic test_vector(input string name, input logic [15:0] sum, input logic [3:0] tag,
                             input logic [6:0] e_m7, input logic [8:0] e_mant,
                             input logic [5:0] e_exp, input logic e_dz);
    tick();
    bus.in_valid = 1'b1; bus.in_sum = sum; bus.in_tag = tag; bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL %s accept: in_ready=%0b want 1", name, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0; bus.in_sum = 16'($urandom); bus.in_tag = 4'($urandom);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL %s early1: out_valid=%0b want 0", name, bus.out_valid); end
    tick(); #1;
    n_checks++; if (bus.lut_m_value !== e_m7) begin n_errors++; $display("FAIL %s lut_m_value: got %0d want %0d", name, bus.lut_m_value, e_m7); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL %s early2: out_valid=%0b want 0", name, bus.out_valid); end
    tick(); #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL %s latency: out_valid=%0b want 1", name, bus.out_valid); end
    n_checks++; if (bus.out_mant !== e_mant) begin n_errors++; $display("FAIL %s out_mant: got %0h want %0h", name, bus.out_mant, e_mant); end
    n_checks++; if (bus.out_exp !== e_exp) begin n_errors++; $display("FAIL %s out_exp: got %0d want %0d", name, $signed(bus.out_exp), $signed(e_exp)); end
    n_checks++; if (bus.out_tag !== tag) begin n_errors++; $display("FAIL %s out_tag: got %0h want %0h", name, bus.out_tag, tag); end
    n_checks++; if (bus.out_dz !== e_dz) begin n_errors++; $display("FAIL %s out_dz: got %0b want %0b", name, bus.out_dz, e_dz); end
    tick(); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL %s duplicate: out_valid=%0b want 0", name, bus.out_valid); end
  endtask

  task automatic test_random_vectors();
    exp_t e;
    int   s;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0) ? int'($urandom_range(1, 65535)) : int'($urandom_range(1, 127));
      e = model(s, 4'(i));
      test_vector("rand_vec", 16'(s), 4'(i), e.m7, e.mant, e.exp, e.dz);
    end
  endtask

  // Stream n tokens; rnd=0 uses out_ready pattern 1,0,0,1 with in_valid held high
  task automatic test_stream(input string name, input int n, input bit rnd);
    int         sums[$];
    exp_t       sb[$];
    exp_t       e;
    int         sent, got, cyc, full_seen, tail;
    logic       hold;
    logic [20:0] snap, now;
    sent = 0; got = 0; cyc = 0; full_seen = 0; hold = 1'b0; snap = '0;
    for (int i = 0; i < n; i++) begin
      if (!rnd && i == 5)                sums.push_back(0);
      else if (rnd && $urandom_range(0, 7) == 0) sums.push_back(0);
      else if ($urandom_range(0, 1) == 1) sums.push_back(int'($urandom_range(1, 63)));
      else                               sums.push_back(int'($urandom_range(1, 65535)));
    end
    tick();
    while ((sent < n || got < n) && cyc < 2000) begin
      bus.in_valid  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_sum    = (sent < n) ? 16'(sums[sent]) : 16'($urandom);
      bus.in_tag    = 4'(sent);
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
      #1;
      now = {bus.out_valid, bus.out_mant, bus.out_exp, bus.out_tag, bus.out_dz};
      if (hold) begin
        n_checks++; if (now !== snap) begin n_errors++; $display("FAIL %s hold: got %0h want %0h", name, now, snap); end
      end
      if (bus.in_valid && !bus.in_ready) begin
        full_seen++;
        n_checks++; if (sent - got != 3) begin n_errors++; $display("FAIL %s stall_depth: in flight %0d want 3", name, sent - got); end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(sums[sent], 4'(sent)));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL %s extra_output: tag %0h with nothing expected", name, bus.out_tag);
        end else begin
          e = sb.pop_front();
          if ({bus.out_mant, bus.out_exp, bus.out_tag, bus.out_dz} !== {e.mant, e.exp, e.tag, e.dz}) begin
            n_errors++;
            $display("FAIL %s beat: got mant=%0h exp=%0h tag=%0h dz=%0b want mant=%0h exp=%0h tag=%0h dz=%0b",
                     name, bus.out_mant, bus.out_exp, bus.out_tag, bus.out_dz, e.mant, e.exp, e.tag, e.dz);
          end
        end
        got++;
      end
      hold = bus.out_valid && !bus.out_ready;
      snap = now;
      tick();
      cyc++;
    end
    n_checks++; if (cyc >= 2000) begin n_errors++; $display("FAIL %s timeout: sent %0d got %0d of %0d", name, sent, got, n); end
    n_checks++; if (got != n || sb.size() != 0) begin n_errors++; $display("FAIL %s count: got %0d want %0d", name, got, n); end
    if (!rnd) begin
      n_checks++; if (full_seen == 0) begin n_errors++; $display("FAIL %s in_ready_drop: stalls seen %0d want >0", name, full_seen); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tail = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.out_valid) tail++;
      tick();
    end
    n_checks++; if (tail != 0) begin n_errors++; $display("FAIL %s tail: extra outputs %0d want 0", name, tail); end
  endtask

  task automatic test_reset_midflight();
    int   cnt, s;
    exp_t e;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_sum = 16'($urandom_range(1, 65535)); bus.in_tag = 4'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL midrst pre: out_valid=%0b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst async: out_valid=%0b want 0", bus.out_valid); end
    n_checks++; if (bus.lut_m_value !== 7'h40) begin n_errors++; $display("FAIL midrst lut: got %0h want 40", bus.lut_m_value); end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1; if (bus.out_valid) cnt++;
    end
    n_checks++; if (cnt != 0) begin n_errors++; $display("FAIL midrst ghost: outputs %0d want 0", cnt); end
    s = int'($urandom_range(1, 65535));
    e = model(s, 4'h9);
    tick();
    bus.in_valid = 1'b1; bus.in_sum = 16'(s); bus.in_tag = 4'h9;
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        cnt++;
        n_checks++; if (bus.out_mant !== e.mant || bus.out_tag !== e.tag) begin n_errors++; $display("FAIL midrst post: got mant=%0h tag=%0h want mant=%0h tag=%0h", bus.out_mant, bus.out_tag, e.mant, e.tag); end
      end
      tick();
    end
    n_checks++; if (cnt != 1) begin n_errors++; $display("FAIL midrst single: outputs %0d want 1", cnt); end
  endtask

  initial begin
    test_reset();
    test_vector("one",     16'h0100, 4'h3, 7'd64,  9'h1FF, 6'h3F, 1'b0);
    test_vector("one_p5",  16'h0180, 4'h5, 7'd96,  9'h155, 6'h3F, 1'b0);
    test_vector("lsb",     16'h0001, 4'h6, 7'd64,  9'h1FF, 6'd7,  1'b0);
    test_vector("allones", 16'hFFFF, 4'hC, 7'd127, 9'h102, 6'h38, 1'b0);
    test_vector("zero",    16'h0000, 4'hA, 7'd64,  9'h1FF, 6'd31, 1'b1);
    test_random_vectors();
    test_stream("back_to_back", 8, 1'b0);
    test_stream("random_stream", 40, 1'b1);
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/softmax_recip_normalizer.md
Name: softmax_recip_normalizer

Overview:
- Pipelined reciprocal front/back end for the softmax denominator.
- Takes the unsigned fixed-point exponent sum and normalises it to mantissa m ∈ [0.5,1) plus a shift.
- Drives the Q0.7 mantissa onto the reciprocal-LUT interface, captures the Q1.8 1/m result, and emits reciprocal = mantissa·2^exp to the divide/scale stage.
- Sits between the exp-accumulator and the per-element multiplier.

Parameters:
- SUM_W, 16, width of the unsigned input sum.
- SUM_FRAC, 8, fractional bits of the input sum (Q(SUM_W-SUM_FRAC).SUM_FRAC).
- EXP_W, 6, width of the signed output exponent.
- TAG_W, 4, sideband tag (row id) carried alongside each sum.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_valid  in  1  input sum valid.
- in_ready  out  1  block can accept input.
- in_sum  in  SUM_W  unsigned sum.
- in_tag  in  TAG_W  sideband tag.
- lut_m_value  out  7  Q0.7 mantissa to the reciprocal LUT, value in [64,127].
- lut_recip  in  9  Q1.8 1/m returned combinationally by the LUT.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  9  Q1.8 reciprocal mantissa.
- out_exp  out  EXP_W  signed exponent; reciprocal = out_mant·2^out_exp.
- out_tag  out  TAG_W  tag of this result.
- out_dz  out  1  input sum was zero.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all stage valids clear, out_valid=0, out_mant=0, out_exp=0, out_tag=0, out_dz=0, lut_m_value=7'h40. in_ready=1 one cycle after reset deasserts.
- Pipeline: S1 → S2 → S3, each with its own valid bit.
  - S1 registers sum and tag. It also registers p (leading-one position, 0..SUM_W-1) and the zero flag.
  - S2 registers the normalised mantissa. m7 = in_sum[p:p-6]. If p<6, the bits are left-aligned with zero fill (m7 = sum<<(6-p)). m7[6] is always 1.
  - S2 also registers exp = SUM_FRAC - p - 1 (signed, EXP_W bits).
  - lut_m_value is driven directly from the S2 register (no combinational input path).
  - S3 captures lut_recip, exp, tag and dz into the out_* registers.
- Latency: 3 cycles from an accepted in_valid&&in_ready to out_valid, with no stall. Throughput is 1 per cycle.
- Flow control: stage k loads when it is empty or stage k+1 loads. S3 "loads" on out_ready || !out_valid. in_ready = S1 load condition. Bubbles collapse.
- Handshake rules:
  - Output registers hold stable while out_valid && !out_ready.
  - A transfer happens only on valid&&ready.
  - in_sum and in_tag are ignored when in_valid=0.
- Zero sum: S1 sets dz and forces m7=7'h40. Output is out_mant=9'h1FF, out_exp=+max (2^(EXP_W-1)-1), out_dz=1. The token still occupies one pipeline slot.
- Exponent arithmetic:
  - Range SUM_FRAC-SUM_W .. SUM_FRAC-1 must fit in EXP_W bits signed.
  - Violation is checked by an elaboration-time assertion.
- Mantissa below bit p-6 is truncated, no rounding.
- Simultaneous accept and emit in the same cycle is legal; no token is lost or duplicated.
- Reset asserted mid-operation: all in-flight tokens are dropped immediately (async). No output follows reset release until new input arrives.

Decomposition:
- softmax_pkg holds:
  - the mantissa/reciprocal widths (7, 9);
  - the LUT floor constant 7'h40;
  - the zero-sum saturation constants (9'h1FF, max exponent);
  - a struct typedef {mant, exp, tag, dz} for the output beat.
- One sub-module, lead_one_det: combinational, SUM_W-bit priority encoder returning p and a zero flag. Instantiated in S1.

Test Plan (SUM_W=16, SUM_FRAC=8; bench LUT model returns round-down Q1.8 of 1/m, 0x1FF at m=64):
- in_sum=0x0100 (1.0) → lut_m_value=7'h40 in cycle 2; out_mant=0x1FF, out_exp=-1, out_dz=0 at latency 3.
- in_sum=0x0180 (1.5) → lut_m_value=96; out_mant=0x155, out_exp=-1 (≈0.6667).
- in_sum=0x0001 → p=0, lut_m_value=64; out_mant=0x1FF, out_exp=+7. in_sum=0xFFFF → lut_m_value=127; out_mant=0x102, out_exp=-8.
- in_sum=0x0000 → out_dz=1, out_mant=0x1FF, out_exp=+31, tag preserved.
- Back-to-back stream of 8 sums with tags 0..7, out_ready toggled 1,0,0,1,…:
  - in_ready drops after 3 stalled tokens;
  - outputs appear in order with matching tags, no loss or duplication;
  - outputs are held stable during stall.
- Reset asserted with 3 tokens in flight → out_valid=0 immediately; after release, one new sum yields exactly one output.
